// File: rtl/tensor_core_instruction_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tensor_core_instruction_sequencer
// Purpose  : Fetches a program from instruction memory, issues words to the
//            tensor core over valid/ready and expands BURST opcodes into
//            operand / result beats. Optional performance counters are built
//            when TENSOR_CORE_SEQ_PERF_COUNTERS_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module tensor_core_instruction_sequencer #(
    parameter int INSTR_WIDTH = 16,
    parameter int DATA_WIDTH  = 16,
    parameter int OUT_WIDTH   = 8,
    parameter int IMEM_AW     = 15,
    parameter int DMEM_AW     = 15,
    parameter int BURST_LEN   = 5
) (
    input  logic                   clock_in,
    input  logic                   reset_in,
    input  logic                   start_in,
    input  logic [IMEM_AW-1:0]     prog_len_in,
    output logic                   imem_rd_en,
    output logic [IMEM_AW-1:0]     imem_addr,
    input  logic [INSTR_WIDTH-1:0] imem_data,
    output logic                   dmem_rd_en,
    output logic [DMEM_AW-1:0]     dmem_addr,
    input  logic [DATA_WIDTH-1:0]  dmem_data,
    output logic                   rmem_wr_en,
    output logic [DMEM_AW-1:0]     rmem_addr,
    output logic [OUT_WIDTH-1:0]   rmem_data,
    output logic [INSTR_WIDTH-1:0] current_tensor_core_instruction,
    output logic                   core_instr_valid,
    input  logic                   core_instr_ready,
    input  logic [OUT_WIDTH-1:0]   tensor_core_controller_output,
    output logic                   core_reset_out,
    output logic                   busy,
    output logic                   done
`ifdef TENSOR_CORE_SEQ_PERF_COUNTERS_EN
    ,
    output logic [31:0]            perf_cycles,
    output logic [31:0]            perf_instrs,
    output logic [31:0]            perf_stalls
`endif
);

    localparam int c_BW = $clog2(BURST_LEN + 1);
    localparam logic [c_BW-1:0] c_LAST = c_BW'(BURST_LEN - 1);

    localparam logic [3:0] c_IDLE   = 4'd0;
    localparam logic [3:0] c_FETCH  = 4'd1;
    localparam logic [3:0] c_DECODE = 4'd2;
    localparam logic [3:0] c_ISSUE  = 4'd3;
    localparam logic [3:0] c_CRST   = 4'd4;
    localparam logic [3:0] c_BREQ   = 4'd5;
    localparam logic [3:0] c_BWAIT  = 4'd6;
    localparam logic [3:0] c_BEAT   = 4'd7;
    localparam logic [3:0] c_NEXT   = 4'd8;
    localparam logic [3:0] c_DONE   = 4'd9;

    localparam logic [1:0] c_OP_BURST = 2'b10;
    localparam logic [1:0] c_OP_RESET = 2'b11;

    logic [3:0]             r_state;
    logic [3:0]             w_next;
    logic [IMEM_AW-1:0]     r_pc;
    logic [IMEM_AW-1:0]     r_prog_len;
    logic [IMEM_AW-1:0]     w_pc_inc;
    logic [DMEM_AW-1:0]     r_dmem_ptr;
    logic [DMEM_AW-1:0]     r_rmem_ptr;
    logic [c_BW-1:0]        r_beat;
    logic [INSTR_WIDTH-1:0] r_instr;
    logic [INSTR_WIDTH-1:0] r_beat_word;
    logic                   w_burst;
    logic                   w_wr_mode;
    logic                   w_rd_mode;
    logic                   w_hs;

    assign w_pc_inc  = r_pc + 1'b1;
    assign w_burst   = (r_instr[1:0] == c_OP_BURST);
    assign w_wr_mode = (r_instr[3:2] == 2'b01) || (r_instr[3:2] == 2'b10);
    assign w_rd_mode = (r_instr[3:2] == 2'b00) || (r_instr[3:2] == 2'b10);
    assign w_hs      = core_instr_valid && core_instr_ready;

    always_ff @(posedge clock_in or posedge reset_in) begin
        if (reset_in) r_state <= c_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_IDLE:   if (start_in) w_next = (prog_len_in == '0) ? c_DONE : c_FETCH;
            c_FETCH:  w_next = c_DECODE;
            c_DECODE: w_next = (imem_data[1:0] == c_OP_RESET) ? c_CRST : c_ISSUE;
            c_ISSUE:  if (core_instr_ready)
                          w_next = !w_burst ? c_NEXT : (w_wr_mode ? c_BREQ : c_BEAT);
            c_CRST:   w_next = c_NEXT;
            c_BREQ:   w_next = c_BWAIT;
            c_BWAIT:  w_next = c_BEAT;
            c_BEAT:   if (core_instr_ready)
                          w_next = (r_beat == c_LAST) ? c_NEXT : (w_wr_mode ? c_BREQ : c_BEAT);
            c_NEXT:   w_next = (w_pc_inc == r_prog_len) ? c_DONE : c_FETCH;
            c_DONE:   w_next = c_IDLE;
            default:  w_next = c_IDLE;
        endcase
    end

    // Datapath: program counter, memory pointers, beat counter and word holding registers.
    always_ff @(posedge clock_in or posedge reset_in) begin
        if (reset_in) begin
            r_pc        <= '0;
            r_prog_len  <= '0;
            r_dmem_ptr  <= '0;
            r_rmem_ptr  <= '0;
            r_beat      <= '0;
            r_instr     <= '0;
            r_beat_word <= '0;
        end else begin
            case (r_state)
                c_IDLE: if (start_in) begin
                    r_pc       <= '0;
                    r_dmem_ptr <= '0;
                    r_rmem_ptr <= '0;
                    r_beat     <= '0;
                    r_prog_len <= prog_len_in;
                end
                // Reserved burst select is downgraded to a plain NOP word.
                c_DECODE: r_instr <= ((imem_data[1:0] == c_OP_BURST) && (imem_data[3:2] == 2'b11))
                                     ? '0 : imem_data;
                c_ISSUE: if (core_instr_ready) begin
                    r_beat      <= '0;
                    r_beat_word <= '0;
                end
                c_BWAIT: r_beat_word <= dmem_data;
                c_BEAT: if (core_instr_ready) begin
                    if (w_wr_mode) r_dmem_ptr <= r_dmem_ptr + 1'b1;
                    if (w_rd_mode) r_rmem_ptr <= r_rmem_ptr + 1'b1;
                    if (r_beat != c_LAST) r_beat <= r_beat + 1'b1;
                end
                c_NEXT: r_pc <= w_pc_inc;
                default: ;
            endcase
        end
    end

    always_comb begin
        imem_rd_en                      = 1'b0;
        dmem_rd_en                      = 1'b0;
        rmem_wr_en                      = 1'b0;
        rmem_data                       = '0;
        current_tensor_core_instruction = '0;
        core_instr_valid                = 1'b0;
        core_reset_out                  = 1'b0;
        done                            = 1'b0;
        case (r_state)
            c_FETCH: imem_rd_en = 1'b1;
            c_ISSUE: begin
                core_instr_valid                = 1'b1;
                current_tensor_core_instruction = r_instr;
            end
            c_CRST:  core_reset_out = 1'b1;
            c_BREQ:  dmem_rd_en = 1'b1;
            c_BEAT: begin
                core_instr_valid                = 1'b1;
                current_tensor_core_instruction = r_beat_word;
                if (core_instr_ready && w_rd_mode) begin
                    rmem_wr_en = 1'b1;
                    rmem_data  = tensor_core_controller_output;
                end
            end
            c_DONE:  done = 1'b1;
            default: ;
        endcase
    end

    assign busy      = (r_state != c_IDLE);
    assign imem_addr = r_pc;
    assign dmem_addr = r_dmem_ptr;
    assign rmem_addr = r_rmem_ptr;

`ifdef TENSOR_CORE_SEQ_PERF_COUNTERS_EN
    logic [31:0] r_perf_cycles;
    logic [31:0] r_perf_instrs;
    logic [31:0] r_perf_stalls;

    always_ff @(posedge clock_in or posedge reset_in) begin
        if (reset_in) begin
            r_perf_cycles <= '0;
            r_perf_instrs <= '0;
            r_perf_stalls <= '0;
        end else if ((r_state == c_IDLE) && start_in) begin
            r_perf_cycles <= '0;
            r_perf_instrs <= '0;
            r_perf_stalls <= '0;
        end else begin
            if (busy && (r_perf_cycles != '1))
                r_perf_cycles <= r_perf_cycles + 32'd1;
            if ((r_state == c_ISSUE) && w_hs && (r_perf_instrs != '1))
                r_perf_instrs <= r_perf_instrs + 32'd1;
            if (core_instr_valid && !core_instr_ready && (r_perf_stalls != '1))
                r_perf_stalls <= r_perf_stalls + 32'd1;
        end
    end

    assign perf_cycles = r_perf_cycles;
    assign perf_instrs = r_perf_instrs;
    assign perf_stalls = r_perf_stalls;
`endif

endmodule
`default_nettype wire
